// File: rtl/swd_engine.sv
// ============================================================================
//  Module      : swd_engine
//  Description : ADIv5 SWD transfer engine. Serialises one SWD transaction
//                per go strobe onto DIO, stepping on SWCLK falling edges.
//                Provides WAIT retry, trailing idle cycles and line reset.
//                Optional feature macro: SWD_WAITRETRY_EN (WAIT retry loop).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swd_engine #(
  parameter int RETRY_W = 8,
  parameter int IDLE_W  = 8,
  parameter int LR_BITS = 56
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               swclk,
  input  logic               swdi,
  output logic               swdo,
  output logic               swwr,
  input  logic [1:0]         turnaround,
  input  logic               dataphase,
  input  logic [RETRY_W-1:0] retries,
  input  logic [IDLE_W-1:0]  idlecycles,
  input  logic               linereset,
  input  logic [1:0]         addr32,
  input  logic               rnw,
  input  logic               apndp,
  input  logic [31:0]        dwrite,
  input  logic               go,
  output logic               idle,
  output logic [2:0]         ack,
  output logic [31:0]        dread,
  output logic               perr,
  output logic [RETRY_W-1:0] nretry
);

  // Phase counter must hold the longest phase: line reset, idle run or 33.
  localparam int c_LRW = $clog2(LR_BITS + 1);
  localparam int c_CW0 = (c_LRW > IDLE_W) ? c_LRW : IDLE_W;
  localparam int c_CW  = (c_CW0 > 6) ? c_CW0 : 6;

  localparam logic [3:0] c_ST_IDLE   = 4'd0;
  localparam logic [3:0] c_ST_LRESET = 4'd1;
  localparam logic [3:0] c_ST_HDR    = 4'd2;
  localparam logic [3:0] c_ST_TRN1   = 4'd3;
  localparam logic [3:0] c_ST_ACK    = 4'd4;
  localparam logic [3:0] c_ST_RDATA  = 4'd5;
  localparam logic [3:0] c_ST_RPAR   = 4'd6;
  localparam logic [3:0] c_ST_TRN2   = 4'd7;
  localparam logic [3:0] c_ST_WDATA  = 4'd8;
  localparam logic [3:0] c_ST_WPAR   = 4'd9;
  localparam logic [3:0] c_ST_TRN3   = 4'd10;
  localparam logic [3:0] c_ST_DPHASE = 4'd11;
  localparam logic [3:0] c_ST_COOL   = 4'd12;

  localparam logic [2:0] c_ACK_OK    = 3'b001;
  localparam logic [2:0] c_ACK_WAIT  = 3'b010;
  localparam logic [2:0] c_ACK_FAULT = 3'b100;

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic              r_swclk_q;
  logic              w_fall;
  logic              w_step;
  logic              w_last;
  logic              w_end;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   w_len;

  // Latched request
  logic [1:0]        r_turn;
  logic              r_dp;
  logic [IDLE_W-1:0] r_idle_n;
  logic              r_lr;
  logic [1:0]        r_addr;
  logic              r_rnw;
  logic              r_apndp;
  logic [31:0]       r_wdata;

  logic [2:0]        r_ack_sh;
  logic [2:0]        w_ack_now;
  logic [31:0]       r_rdata;
  logic [7:0]        w_hdr;
  logic              w_retry;
  logic [3:0]        w_after_cool;
  logic [3:0]        w_cool_tgt;

  logic              w_do;
  logic              w_wr;

  assign w_fall    = r_swclk_q & ~swclk;
  assign w_step    = w_fall && (r_state != c_ST_IDLE);
  assign w_last    = (r_cnt == (w_len - c_CW'(1)));
  assign w_end     = w_step && w_last;
  assign w_ack_now = {swdi, r_ack_sh[1:0]};
  assign idle      = (r_state == c_ST_IDLE);

  // Header, LSB first: start, APnDP, RnW, A2, A3, parity, stop, park
  assign w_hdr = {1'b1, 1'b0, ^{r_apndp, r_rnw, r_addr}, r_addr[1], r_addr[0],
                  r_rnw, r_apndp, 1'b1};

`ifdef SWD_WAITRETRY_EN
  logic [RETRY_W-1:0] r_retries;
  logic [RETRY_W-1:0] r_nretry;

  assign w_retry = !r_lr && (r_ack_sh == c_ACK_WAIT) && (r_nretry < r_retries);
  assign nretry  = r_nretry;

  // Retry bookkeeping: limit latched at accept, counter stepped on each re-entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retries <= '0;
      r_nretry  <= '0;
    end else if ((r_state == c_ST_IDLE) && go) begin
      r_retries <= retries;
      r_nretry  <= '0;
    end else if (w_end && (w_next == c_ST_HDR)) begin
      r_nretry  <= r_nretry + RETRY_W'(1);
    end
  end
`else
  logic w_unused_retries;
  assign w_unused_retries = ^retries;
  assign w_retry          = 1'b0;
  assign nretry           = '0;
`endif

  // A zero-length idle run skips COOL and resolves its exit immediately
  assign w_after_cool = w_retry ? c_ST_HDR : c_ST_IDLE;
  assign w_cool_tgt   = (r_idle_n == '0) ? w_after_cool : c_ST_COOL;

  // Number of falling edges spent in the current phase
  always_comb begin
    w_len = c_CW'(1);
    case (r_state)
      c_ST_LRESET: w_len = c_CW'(LR_BITS);
      c_ST_HDR:    w_len = c_CW'(8);
      c_ST_TRN1,
      c_ST_TRN2,
      c_ST_TRN3:   w_len = c_CW'(r_turn) + c_CW'(1);
      c_ST_ACK:    w_len = c_CW'(3);
      c_ST_RDATA,
      c_ST_WDATA:  w_len = c_CW'(32);
      c_ST_DPHASE: w_len = c_CW'(33);
      c_ST_COOL:   w_len = c_CW'(r_idle_n);
      default:     w_len = c_CW'(1);
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; phases advance only on their final falling edge
  always_comb begin
    w_next = r_state;
    if (r_state == c_ST_IDLE) begin
      if (go) w_next = linereset ? c_ST_LRESET : c_ST_HDR;
    end else if (w_end) begin
      case (r_state)
        c_ST_LRESET: w_next = w_cool_tgt;
        c_ST_HDR:    w_next = c_ST_TRN1;
        c_ST_TRN1:   w_next = c_ST_ACK;
        c_ST_ACK: begin
          if (w_ack_now == c_ACK_OK) w_next = r_rnw ? c_ST_RDATA : c_ST_TRN2;
          else                       w_next = c_ST_TRN3;
        end
        c_ST_RDATA:  w_next = c_ST_RPAR;
        c_ST_RPAR:   w_next = c_ST_TRN3;
        c_ST_TRN2:   w_next = c_ST_WDATA;
        c_ST_WDATA:  w_next = c_ST_WPAR;
        c_ST_WPAR:   w_next = w_cool_tgt;
        c_ST_TRN3: begin
          if (((r_ack_sh == c_ACK_WAIT) || (r_ack_sh == c_ACK_FAULT)) && r_dp)
            w_next = c_ST_DPHASE;
          else
            w_next = w_cool_tgt;
        end
        c_ST_DPHASE: w_next = w_cool_tgt;
        c_ST_COOL:   w_next = w_after_cool;
        default:     w_next = c_ST_IDLE;
      endcase
    end
  end

  // Pin values to present at the current falling edge
  always_comb begin
    w_do = 1'b0;
    w_wr = swwr;
    case (r_state)
      c_ST_LRESET: begin w_do = 1'b1; w_wr = 1'b1; end
      c_ST_HDR:    begin w_do = w_hdr[r_cnt[2:0]]; w_wr = 1'b1; end
      c_ST_TRN1,
      c_ST_ACK,
      c_ST_RDATA,
      c_ST_RPAR:   w_wr = 1'b0;
      c_ST_TRN2,
      c_ST_TRN3:   w_wr = w_last;
      c_ST_WDATA:  begin w_do = r_wdata[r_cnt[4:0]]; w_wr = 1'b1; end
      c_ST_WPAR:   begin w_do = ^r_wdata; w_wr = 1'b1; end
      c_ST_DPHASE,
      c_ST_COOL:   w_wr = 1'b1;
      default:     w_wr = swwr;
    endcase
  end

  // Edge detect, request latch, pin drive, sampling and result commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_swclk_q <= 1'b0;
      r_cnt     <= '0;
      r_turn    <= '0;
      r_dp      <= 1'b0;
      r_idle_n  <= '0;
      r_lr      <= 1'b0;
      r_addr    <= '0;
      r_rnw     <= 1'b0;
      r_apndp   <= 1'b0;
      r_wdata   <= '0;
      r_ack_sh  <= '0;
      r_rdata   <= '0;
      swdo      <= 1'b0;
      swwr      <= 1'b1;
      ack       <= '0;
      dread     <= '0;
      perr      <= 1'b0;
    end else begin
      r_swclk_q <= swclk;
      if ((r_state == c_ST_IDLE) && go) begin
        r_turn   <= turnaround;
        r_dp     <= dataphase;
        r_idle_n <= idlecycles;
        r_lr     <= linereset;
        r_addr   <= addr32;
        r_rnw    <= rnw;
        r_apndp  <= apndp;
        r_wdata  <= dwrite;
        r_ack_sh <= '0;
        r_cnt    <= '0;
        perr     <= 1'b0;
      end
      if (w_step) begin
        swdo  <= w_do;
        swwr  <= w_wr;
        r_cnt <= w_last ? '0 : (r_cnt + c_CW'(1));
        case (r_state)
          c_ST_ACK:   r_ack_sh[r_cnt[1:0]] <= swdi;
          c_ST_RDATA: r_rdata[r_cnt[4:0]]  <= swdi;
          c_ST_RPAR:  perr <= ^{r_rdata, swdi};
          default:    ;
        endcase
        if (w_end && (w_next == c_ST_IDLE) && !r_lr) begin
          ack <= r_ack_sh;
          if (r_rnw && (r_ack_sh == c_ACK_OK)) dread <= r_rdata;
        end
      end
    end
  end

endmodule

`default_nettype wire
